sync_fifo_packer: RTL and testbench

- Upstream feeder for the IN_DEPTH-lane sync FIFO.
- Accepts a scalar stream of WIDTH-bit elements over a valid/ready handshake and packs IN_DEPTH consecutive elements into one row.
- Pushes each row into the FIFO write port and holds it until the FIFO accepts it.
- A row cut short by in_last is zero-padded on its unused lanes and flushed immediately.

---
 rtl/sync_fifo_packer.sv | 64 ++++++
 tb/tb_sync_fifo_packer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_packer.sv
// sync_fifo_packer: packs IN_DEPTH scalar elements per FIFO row; define SYNC_FIFO_PACKER_THROTTLE_EN to hold off new rows while almost_full
module sync_fifo_packer #(
  parameter int WIDTH = 32,
  parameter int IN_DEPTH = 6,
  parameter int CNT_W = 16,
  localparam int IW = $clog2(IN_DEPTH),
  localparam int LW = $clog2(IN_DEPTH + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_data,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic                            wr_en,
  output logic [IN_DEPTH-1:0][WIDTH-1:0]  wr_data,
  input  logic                            wr_valid,
  input  logic                            full,
  input  logic                            almost_full,
  output logic [LW-1:0]                   lanes_used,
  output logic [CNT_W-1:0]                rows_pushed
);
  typedef enum logic {FILL, PUSH} state_t;
  state_t state, state_n;
  logic [IN_DEPTH-1:0][WIDTH-1:0] row;
  logic [IW-1:0] idx;
  logic [LW-1:0] cnt;
  logic accept, flush, unused_in;
  assign unused_in = full ^ almost_full;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= FILL;
    else state <= state_n;
  always_comb begin
    wr_en = state == PUSH;
    lanes_used = wr_en ? cnt : '0;
`ifdef SYNC_FIFO_PACKER_THROTTLE_EN
    in_ready = state == FILL && (idx != '0 || !almost_full);
`else
    in_ready = state == FILL;
`endif
    accept = in_valid && in_ready;
    flush = accept && (idx == IW'(IN_DEPTH - 1) || in_last);
    state_n = flush ? PUSH : (wr_en && wr_valid) ? FILL : state;
    for (int i = 0; i < IN_DEPTH; i++) wr_data[i] = (wr_en && LW'(i) < cnt) ? row[i] : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      row <= '0;
      idx <= '0;
      cnt <= '0;
      rows_pushed <= '0;
    end else begin
      if (accept) begin
        row[idx] <= in_data;
        idx <= flush ? '0 : idx + 1'b1;
      end
      if (flush) cnt <= LW'(idx) + LW'(1);
      // buffer is cleared on acceptance so a short next row carries no stale lanes
      if (wr_en && wr_valid) begin
        row <= '0;
        rows_pushed <= rows_pushed + 1'b1;
      end
    end
endmodule

// File: tb/tb_sync_fifo_packer.sv
// tb_sync_fifo_packer: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_sync_fifo_packer;
  localparam int W = 32, D = 6, CW = 4, LW = $clog2(D + 1);
  typedef logic [D-1:0][W-1:0] row_t;
  typedef struct { row_t d; int n; } exp_t;
  logic clock = 0, reset = 0, in_valid = 0, in_last = 0, full = 0, almost_full = 0;
  logic auto_ack = 1, man_ack = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, wr_en, wr_valid;
  row_t wr_data, stall_row;
  logic [LW-1:0] lanes_used;
  logic [CW-1:0] rows_pushed;
  exp_t q[$];
  row_t m_row = '0;
  int m_n = 0, total = 0, bad = 0;
  assign wr_valid = auto_ack ? wr_en : man_ack;
  always #5 clock = ~clock;
  sync_fifo_packer #(.WIDTH(W), .IN_DEPTH(D), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_en(wr_en), .wr_data(wr_data), .wr_valid(wr_valid), .full(full),
    .almost_full(almost_full), .lanes_used(lanes_used), .rows_pushed(rows_pushed));
  task automatic chk(input string nm, input logic [D*W-1:0] a, input logic [D*W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      chk("ready_with_wr_en", in_ready && wr_en, 0);
      if (wr_en && wr_valid) begin
        if (q.size() == 0) chk("unexpected_row", 1, 0);
        else begin
          e = q.pop_front();
          chk("row_data", wr_data, e.d);
          chk("row_lanes", lanes_used, e.n);
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] d, input logic l);
    int t = 0;
    in_valid = 1; in_data = d; in_last = l;
    while (!in_ready && t < 50) begin @(posedge clock); #1; t++; end
    if (!in_ready) begin
      chk("send_timeout", 1, 0);
      in_valid = 0; in_last = 0;
      return;
    end
    @(posedge clock); #1;
    in_valid = 0; in_last = 0;
    m_row[m_n] = d;
    m_n++;
    if (m_n == D || l) begin
      q.push_back('{m_row, m_n});
      m_row = '0;
      m_n = 0;
    end
  endtask
  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_lanes", lanes_used, 0);
    chk("rst_rows", rows_pushed, 0);
    chk("rst_ready", in_ready, 1);
    #1 reset = 0;
    q.delete();
    m_row = '0;
    m_n = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clock); #1; t++; end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clock); #1;
    do_reset();
    for (int i = 1; i <= 5; i++) send(W'(i), 0);
    chk("t1_no_early_wr_en", wr_en, 0);
    send(6, 0);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_lanes", lanes_used, 6);
    chk("t1_ready_low", in_ready, 0);
    chk("t1_rows_before", rows_pushed, 0);
    @(posedge clock); #1;
    chk("t1_wr_en_drop", wr_en, 0);
    chk("t1_ready_back", in_ready, 1);
    chk("t1_rows", rows_pushed, 1);
    send(32'hA, 0);
    send(32'hB, 1);
    chk("t2_wr_en", wr_en, 1);
    chk("t2_lanes", lanes_used, 2);
    for (int i = 0; i < D; i++) send(32'h21 + W'(i), 0);
    wait_idle();
    chk("t2_rows", rows_pushed, 3);
    auto_ack = 0; man_ack = 0; full = 1;
    for (int i = 0; i < D; i++) begin
      stall_row[i] = 32'h31 + W'(i);
      send(32'h31 + W'(i), 0);
    end
    repeat (5) begin
      @(negedge clock);
      chk("t3_hold_wr_en", wr_en, 1);
      chk("t3_hold_ready", in_ready, 0);
      chk("t3_hold_data", wr_data, stall_row);
      chk("t3_hold_lanes", lanes_used, 6);
      chk("t3_hold_rows", rows_pushed, 3);
    end
    @(posedge clock); #1;
    man_ack = 1; full = 0;
    @(posedge clock); #1;
    man_ack = 0; auto_ack = 1;
    chk("t3_rows", rows_pushed, 4);
    chk("t3_wr_en_drop", wr_en, 0);
    chk("t3_ready_back", in_ready, 1);
    for (int i = 0; i < 3; i++) send(32'h41 + W'(i), 0);
    do_reset();
    for (int i = 0; i < D; i++) send(32'h51 + W'(i), 0);
    send(32'h61, 0);
    send(32'h62, 1);
    wait_idle();
    chk("t4_rows", rows_pushed, 2);
    almost_full = 1;
`ifdef SYNC_FIFO_PACKER_THROTTLE_EN
    repeat (3) begin
      @(negedge clock);
      chk("t5_throttled", in_ready, 0);
    end
    @(posedge clock); #1;
    almost_full = 0;
    chk("t5_released", in_ready, 1);
`else
    @(negedge clock);
    chk("t5_af_ignored", in_ready, 1);
    @(posedge clock); #1;
`endif
    for (int i = 0; i < D; i++) send(32'h71 + W'(i), 0);
    wait_idle();
    almost_full = 0;
    for (int i = 0; i < 3; i++) send(32'h81 + W'(i), 0);
    almost_full = 1;
    #1 chk("t5_mid_row_ready", in_ready, 1);
    for (int i = 3; i < D; i++) send(32'h81 + W'(i), 0);
    wait_idle();
    almost_full = 0;
    chk("t5_rows", rows_pushed, 4);
    @(posedge clock); #1;
    do_reset();
    for (int r = 0; r < 17; r++) begin
      int len;
      len = (r % D) + 1;
      for (int l = 0; l < len; l++) send(32'h1000 * W'(r) + W'(l) + 1, l == len - 1);
    end
    wait_idle();
    chk("t6_wrap", rows_pushed, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
